rrf: RTL

Retirement register file for the out-of-order core: the consumer end of the reorder buffer's retire port. Each retiring ROB entry updates the committed architectural-to-physical mapping. The displaced physical register is queued for return to the free list. On a jump commit (flush), the block streams the full committed mapping back to the rename table, one entry per cycle.

---
 rtl/rrf_if.sv | 30 +++
 rtl/rrf.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rrf_if.sv
// Retire-side bundle between the ROB, the free list, the rename table and rrf.
// master drives retire/flush/free_ready; slave (rrf) answers.
interface rrf_if #(
   parameter int DATA_WIDTH = 12,
   parameter int PS_WIDTH   = 6
);
   logic                  commit_valid;
   logic [DATA_WIDTH-1:0] commit_data;
   logic                  commit_stall;
   logic                  flush;
   logic                  free_valid;
   logic [PS_WIDTH-1:0]   free_pd;
   logic                  free_ready;
   logic                  restore_valid;
   logic [4:0]            restore_ar;
   logic [PS_WIDTH-1:0]   restore_pd;
   logic                  busy;

   modport master (
      output commit_valid, commit_data, flush, free_ready,
      input  commit_stall, free_valid, free_pd,
      input  restore_valid, restore_ar, restore_pd, busy
   );

   modport slave (
      input  commit_valid, commit_data, flush, free_ready,
      output commit_stall, free_valid, free_pd,
      output restore_valid, restore_ar, restore_pd, busy
   );
endinterface

// File: rtl/rrf.sv
// Retirement register file: committed arch->phys map, freed-pd FIFO,
// and a one-entry-per-cycle restore stream to rename on a jump commit.
module rrf #(
   parameter int DATA_WIDTH   = 12,
   parameter int PS_WIDTH     = 6,
   parameter int AR_COUNT     = 32,
   parameter int FREE_Q_DEPTH = 4
) (
   input logic  clk,
   input logic  rst,
   rrf_if.slave bus
);
   localparam int PW = $clog2(FREE_Q_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, RESTORE} state_t;

   state_t              state_q, state_d;
   logic [4:0]          idx_q, idx_d;
   logic [PS_WIDTH-1:0] map_q [AR_COUNT];
   logic [PS_WIDTH-1:0] map_d [AR_COUNT];
   logic [PS_WIDTH-1:0] fifo_q [FREE_Q_DEPTH];
   logic [PS_WIDTH-1:0] fifo_d [FREE_Q_DEPTH];
   logic [PW-1:0]       wr_q, wr_d;
   logic [PW-1:0]       rd_q, rd_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic [4:0]          rd;
   logic [PS_WIDTH-1:0] pd;
   logic                stall;
   logic                accept;
   logic                push;
   logic                pop;
   logic                unused_flag;

   assign rd          = bus.commit_data[4:0];
   assign pd          = bus.commit_data[5 +: PS_WIDTH];
   assign unused_flag = ^bus.commit_data[DATA_WIDTH-1:5+PS_WIDTH];

   // Stall only from registered state so the ROB sees a clean signal.
   assign stall  = (cnt_q == CW'(FREE_Q_DEPTH)) || (state_q == RESTORE);
   assign accept = bus.commit_valid && !stall;
   assign push   = accept && (rd != 5'd0);
   assign pop    = (cnt_q != '0) && bus.free_ready;

   assign bus.commit_stall  = stall;
   assign bus.free_valid    = (cnt_q != '0);
   assign bus.free_pd       = (cnt_q != '0) ? fifo_q[rd_q] : '0;
   assign bus.restore_valid = (state_q == RESTORE);
   assign bus.busy          = (state_q == RESTORE);
   assign bus.restore_ar    = (state_q == RESTORE) ? idx_q : 5'd0;
   assign bus.restore_pd    = (state_q == RESTORE) ? map_q[idx_q] : '0;

   // Committed map update; ar 0 is never written since push needs rd!=0.
   always_comb begin
      map_d = map_q;
      if (push) map_d[rd] = pd;
   end

   // Freed-pd FIFO: push the displaced mapping, pop on free handshake.
   always_comb begin
      fifo_d = fifo_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      if (push) begin
         fifo_d[wr_q] = map_q[rd];
         wr_d         = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Restore sequencer; a flush always (re)starts the walk at ar 0.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (bus.flush) begin
               state_d = RESTORE;
               idx_d   = 5'd0;
            end
         end
         RESTORE: begin
            if (bus.flush) begin
               idx_d = 5'd0;
            end else if (idx_q == 5'(AR_COUNT - 1)) begin
               state_d = IDLE;
               idx_d   = 5'd0;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 5'd0;
         end
      endcase
   end

   // State registers with synchronous active-low reset to identity map.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= 5'd0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < AR_COUNT; i++) map_q[i] <= PS_WIDTH'(i);
         for (int i = 0; i < FREE_Q_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         map_q   <= map_d;
         fifo_q  <= fifo_d;
      end
   end
endmodule
